// File: rtl/core_pipmem.sv
// core_pipmem: memory-access stage. Issues byte/half/word loads and stores
// over a req/gnt/rvalid port, aligns and extends load data, and produces a
// one-cycle register-file write. o_StallEn holds the pipeline while a memory
// transaction is in flight.
module core_pipmem #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        i_Clk,
  input  logic        i_Rstn,
  input  logic        i_LD_WR,
  input  logic        i_WriteEn,
  input  logic [3:0]  i_Oper_sel,
  input  logic [4:0]  i_RegFAddr,
  input  logic [31:0] i_WriteAddr,
  input  logic [31:0] i_WriteData,
  output logic        o_DMem_req,
  output logic        o_DMem_we,
  output logic [3:0]  o_DMem_be,
  output logic [31:0] o_DMem_addr,
  output logic [31:0] o_DMem_wdata,
  input  logic        i_DMem_gnt,
  input  logic        i_DMem_rvalid,
  input  logic [31:0] i_DMem_rdata,
  output logic        o_RegWrEn,
  output logic [4:0]  o_RegFAddr,
  output logic [31:0] o_RegFData,
  output logic        o_StallEn,
  output logic        o_Event
);

  // Operation-select encoding shared with the execute stage.
  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        req_reg, req_next;
  logic        we_reg, we_next;
  logic [3:0]  be_reg, be_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  op_reg, op_next;
  logic [1:0]  lane_reg, lane_next;
  logic [4:0]  rd_reg, rd_next;
  logic        regwr_reg, regwr_next;
  logic [4:0]  regaddr_reg, regaddr_next;
  logic [31:0] regdata_reg, regdata_next;
  logic        event_reg, event_next;

  // Decode of the incoming EX bundle (only meaningful in IDLE).
  logic        is_store, is_load;
  logic        op_is_st, op_is_ld, op_half, op_word;
  logic        misalign, bad_access;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  // Load-data lane selection.
  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ld_data;
  logic [7:0]  cnt_inc;

  assign is_store = i_WriteEn;
  assign is_load  = i_LD_WR & ~i_WriteEn;
  assign cnt_inc  = cnt_reg + 8'd1;

  // Classify the op and detect misalignment / illegal op for the request.
  always_comb begin
    op_is_st = (i_Oper_sel == OP_SB) || (i_Oper_sel == OP_SH) || (i_Oper_sel == OP_SW);
    op_is_ld = (i_Oper_sel == OP_LB) || (i_Oper_sel == OP_LH) || (i_Oper_sel == OP_LW) ||
               (i_Oper_sel == OP_LBU) || (i_Oper_sel == OP_LHU);
    op_half  = (i_Oper_sel == OP_LH) || (i_Oper_sel == OP_LHU) || (i_Oper_sel == OP_SH);
    op_word  = (i_Oper_sel == OP_LW) || (i_Oper_sel == OP_SW);
    misalign = (op_half && i_WriteAddr[0]) || (op_word && (i_WriteAddr[1:0] != 2'b00));
    bad_access = (is_store && (!op_is_st || misalign)) ||
                 (is_load  && (!op_is_ld || misalign));
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = i_WriteData;
    case (i_Oper_sel)
      OP_SB: begin
        st_be    = 4'b0001 << i_WriteAddr[1:0];
        st_wdata = {4{i_WriteData[7:0]}};
      end
      OP_SH: begin
        st_be    = i_WriteAddr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{i_WriteData[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = i_WriteData;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_byte[gi] = i_DMem_rdata[8*gi +: 8];
    end
  endgenerate

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    sel_byte = rd_byte[lane_reg];
    sel_half = lane_reg[1] ? i_DMem_rdata[31:16] : i_DMem_rdata[15:0];
    case (op_reg)
      OP_LB:   ld_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  ld_data = {24'd0, sel_byte};
      OP_LH:   ld_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  ld_data = {16'd0, sel_half};
      default: ld_data = i_DMem_rdata;
    endcase
  end

  // Next-state and next-output logic for the IDLE/REQ/WAIT controller.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    req_next     = req_reg;
    we_next      = we_reg;
    be_next      = be_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    op_next      = op_reg;
    lane_next    = lane_reg;
    rd_next      = rd_reg;
    regwr_next   = 1'b0;
    regaddr_next = regaddr_reg;
    regdata_next = regdata_reg;
    event_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bad_access) begin
          // Faulting access: report it and stay put, nothing is issued.
          event_next = 1'b1;
        end else if (is_store) begin
          state_next = S_REQ;
          cnt_next   = 8'd0;
          req_next   = 1'b1;
          we_next    = 1'b1;
          be_next    = st_be;
          addr_next  = {i_WriteAddr[31:2], 2'b00};
          wdata_next = st_wdata;
          // A store that also carries the load flag is still executed.
          event_next = i_LD_WR;
        end else if (is_load) begin
          state_next = S_REQ;
          cnt_next   = 8'd0;
          req_next   = 1'b1;
          we_next    = 1'b0;
          be_next    = 4'b1111;
          addr_next  = {i_WriteAddr[31:2], 2'b00};
          op_next    = i_Oper_sel;
          lane_next  = i_WriteAddr[1:0];
          rd_next    = i_RegFAddr;
        end else begin
          regwr_next   = (i_RegFAddr != 5'd0);
          regaddr_next = i_RegFAddr;
          regdata_next = i_WriteData;
        end
      end
      S_REQ: begin
        cnt_next = cnt_inc;
        if (i_DMem_gnt) begin
          req_next   = 1'b0;
          cnt_next   = 8'd0;
          state_next = we_reg ? S_IDLE : S_WAIT;
        end else if (cnt_inc == WAIT_LIMIT) begin
          req_next   = 1'b0;
          event_next = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_inc;
        if (i_DMem_rvalid) begin
          regwr_next   = (rd_reg != 5'd0);
          regaddr_next = rd_reg;
          regdata_next = ld_data;
          state_next   = S_IDLE;
        end else if (cnt_inc == WAIT_LIMIT) begin
          event_next = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything including the port.
  always_ff @(posedge i_Clk) begin
    if (!i_Rstn) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      be_reg      <= 4'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      op_reg      <= 4'd0;
      lane_reg    <= 2'd0;
      rd_reg      <= 5'd0;
      regwr_reg   <= 1'b0;
      regaddr_reg <= 5'd0;
      regdata_reg <= 32'd0;
      event_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      req_reg     <= req_next;
      we_reg      <= we_next;
      be_reg      <= be_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      op_reg      <= op_next;
      lane_reg    <= lane_next;
      rd_reg      <= rd_next;
      regwr_reg   <= regwr_next;
      regaddr_reg <= regaddr_next;
      regdata_reg <= regdata_next;
      event_reg   <= event_next;
    end
  end

  assign o_DMem_req   = req_reg;
  assign o_DMem_we    = we_reg;
  assign o_DMem_be    = be_reg;
  assign o_DMem_addr  = addr_reg;
  assign o_DMem_wdata = wdata_reg;
  assign o_RegWrEn    = regwr_reg;
  assign o_RegFAddr   = regaddr_reg;
  assign o_RegFData   = regdata_reg;
  assign o_StallEn    = (state_reg != S_IDLE);
  assign o_Event      = event_reg;

endmodule

// File: tb/tb_core_pipmem.sv
// tb_core_pipmem: directed stimulus with a scoreboard. The stimulus process
// queues expected writebacks, requests and fault events; a monitor process
// pops and compares them whenever the DUT presents the matching output.
module tb_core_pipmem;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ld_wr = 1'b0, write_en = 1'b0;
  logic [3:0]  oper_sel = 4'd0;
  logic [4:0]  reg_faddr = 5'd0;
  logic [31:0] write_addr = 32'd0, write_data = 32'd0;
  logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        o_DMem_req, o_DMem_we, o_RegWrEn, o_StallEn, o_Event;
  logic [3:0]  o_DMem_be;
  logic [31:0] o_DMem_addr, o_DMem_wdata, o_RegFData;
  logic [4:0]  o_RegFAddr;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   ev_q[$];
  int   n_checks = 0;
  int   n_fails = 0;

  core_pipmem #(.MAX_WAIT(4)) dut (
    .i_Clk(clk), .i_Rstn(rstn),
    .i_LD_WR(ld_wr), .i_WriteEn(write_en), .i_Oper_sel(oper_sel),
    .i_RegFAddr(reg_faddr), .i_WriteAddr(write_addr), .i_WriteData(write_data),
    .o_DMem_req(o_DMem_req), .o_DMem_we(o_DMem_we), .o_DMem_be(o_DMem_be),
    .o_DMem_addr(o_DMem_addr), .o_DMem_wdata(o_DMem_wdata),
    .i_DMem_gnt(dmem_gnt), .i_DMem_rvalid(dmem_rvalid), .i_DMem_rdata(dmem_rdata),
    .o_RegWrEn(o_RegWrEn), .o_RegFAddr(o_RegFAddr), .o_RegFData(o_RegFData),
    .o_StallEn(o_StallEn), .o_Event(o_Event)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_wr = 1'b0; write_en = 1'b0; oper_sel = 4'd0;
    reg_faddr = 5'd0; write_addr = 32'd0; write_data = 32'd0;
  endtask

  task automatic issue(input logic ld, input logic we, input logic [3:0] op,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] data);
    ld_wr = ld; write_en = we; oper_sel = op;
    reg_faddr = rd; write_addr = addr; write_data = data;
    step();
    idle_inputs();
  endtask

  // Load with immediate gnt and rvalid one cycle later.
  task automatic do_load(input string name, input logic [3:0] op, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp);
    req_q.push_back('{we: 1'b0, be: 4'b1111, addr: {addr[31:2], 2'b00}, wdata: 32'd0, chk_wdata: 1'b0});
    if (rd != 5'd0) wb_q.push_back('{rd: rd, data: exp});
    issue(1'b1, 1'b0, op, rd, addr, 32'd0);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check({name, "_stall_req"}, 32'(o_StallEn), 32'd1);
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = rdata;
    @(negedge clk);
    check({name, "_stall_wait"}, 32'(o_StallEn), 32'd1);
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'd0;
    @(negedge clk);
    check({name, "_stall_done"}, 32'(o_StallEn), 32'd0);
    step();
  endtask

  // Monitor: compare DUT outputs against the scoreboard queues.
  initial begin
    logic prev_req;
    wb_t  w;
    req_t r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (o_RegWrEn) begin
        if (wb_q.size() == 0) begin
          check("unexpected_writeback_rd", 32'(o_RegFAddr), 32'hFFFF_FFFF);
        end else begin
          w = wb_q.pop_front();
          check("wb_rd", 32'(o_RegFAddr), 32'(w.rd));
          check("wb_data", o_RegFData, w.data);
        end
      end
      if (o_Event) begin
        if (ev_q.size() == 0) check("unexpected_event", 32'd1, 32'd0);
        else void'(ev_q.pop_front());
      end
      if (o_DMem_req && !prev_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_req_addr", o_DMem_addr, 32'hFFFF_FFFF);
        end else begin
          r = req_q.pop_front();
          check("req_we", 32'(o_DMem_we), 32'(r.we));
          check("req_be", 32'(o_DMem_be), 32'(r.be));
          check("req_addr", o_DMem_addr, r.addr);
          if (r.chk_wdata) check("req_wdata", o_DMem_wdata, r.wdata);
        end
      end
      prev_req = o_DMem_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(o_DMem_req), 32'd0);
    check("rst_we", 32'(o_DMem_we), 32'd0);
    check("rst_be", 32'(o_DMem_be), 32'd0);
    check("rst_addr", o_DMem_addr, 32'd0);
    check("rst_wdata", o_DMem_wdata, 32'd0);
    check("rst_regwr", 32'(o_RegWrEn), 32'd0);
    check("rst_regaddr", 32'(o_RegFAddr), 32'd0);
    check("rst_regdata", o_RegFData, 32'd0);
    check("rst_stall", 32'(o_StallEn), 32'd0);
    check("rst_event", 32'(o_Event), 32'd0);
    step();
    rstn = 1'b1;
    step();

    // ALU passthrough, then the same op to x0 (no writeback).
    wb_q.push_back('{rd: 5'd5, data: 32'h1234_5678});
    issue(1'b0, 1'b0, 4'd0, 5'd5, 32'h0, 32'h1234_5678);
    @(negedge clk);
    check("alu_regwr", 32'(o_RegWrEn), 32'd1);
    issue(1'b0, 1'b0, 4'd0, 5'd0, 32'h0, 32'h1234_5678);
    @(negedge clk);
    check("alu_x0_regwr", 32'(o_RegWrEn), 32'd0);
    step();

    // SB to 0x1003 with gnt held low for three cycles.
    req_q.push_back('{we: 1'b1, be: 4'b1000, addr: 32'h1000, wdata: 32'hABAB_ABAB, chk_wdata: 1'b1});
    issue(1'b0, 1'b1, OP_SB, 5'd0, 32'h1003, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sb_hold_req", 32'(o_DMem_req), 32'd1);
      check("sb_hold_stall", 32'(o_StallEn), 32'd1);
      check("sb_hold_addr", o_DMem_addr, 32'h1000);
      step();
    end
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    @(negedge clk);
    check("sb_done_req", 32'(o_DMem_req), 32'd0);
    check("sb_done_stall", 32'(o_StallEn), 32'd0);
    step();

    // Loads with lane extraction and extension.
    do_load("lb",  OP_LB,  5'd7,  32'h2002, 32'h0080_0000, 32'hFFFF_FF80);
    do_load("lbu", OP_LBU, 5'd8,  32'h2002, 32'h0080_0000, 32'h0000_0080);
    do_load("lh",  OP_LH,  5'd9,  32'h2002, 32'h8001_0000, 32'hFFFF_8001);
    do_load("lhu", OP_LHU, 5'd10, 32'h2002, 32'h8001_0000, 32'h0000_8001);
    do_load("lw",  OP_LW,  5'd11, 32'h2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb0", OP_LB,  5'd12, 32'h2001, 32'h0000_7F00, 32'h0000_007F);

    // Misaligned LW and SH: event pulse only.
    ev_q.push_back(1);
    issue(1'b1, 1'b0, OP_LW, 5'd3, 32'h3001, 32'd0);
    @(negedge clk);
    check("lw_mis_event", 32'(o_Event), 32'd1);
    check("lw_mis_req", 32'(o_DMem_req), 32'd0);
    check("lw_mis_stall", 32'(o_StallEn), 32'd0);
    step();
    ev_q.push_back(2);
    issue(1'b0, 1'b1, OP_SH, 5'd0, 32'h3001, 32'h1111);
    @(negedge clk);
    check("sh_mis_event", 32'(o_Event), 32'd1);
    check("sh_mis_req", 32'(o_DMem_req), 32'd0);
    check("sh_mis_stall", 32'(o_StallEn), 32'd0);
    step();
    @(negedge clk);
    check("sh_mis_event_low", 32'(o_Event), 32'd0);

    // Load and store flags together: store executes and event pulses.
    ev_q.push_back(3);
    req_q.push_back('{we: 1'b1, be: 4'b1111, addr: 32'h4000, wdata: 32'hCAFE_F00D, chk_wdata: 1'b1});
    issue(1'b1, 1'b1, OP_SW, 5'd4, 32'h4000, 32'hCAFE_F00D);
    dmem_gnt = 1'b1;
    @(negedge clk);
    check("both_event", 32'(o_Event), 32'd1);
    step();
    dmem_gnt = 1'b0;
    step();

    // Watchdog: LW granted but rvalid never arrives.
    ev_q.push_back(4);
    req_q.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h5000, wdata: 32'd0, chk_wdata: 1'b0});
    issue(1'b1, 1'b0, OP_LW, 5'd13, 32'h5000, 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wd_wait_stall", 32'(o_StallEn), 32'd1);
      check("wd_wait_req", 32'(o_DMem_req), 32'd0);
      step();
    end
    @(negedge clk);
    check("wd_event", 32'(o_Event), 32'd1);
    check("wd_stall_low", 32'(o_StallEn), 32'd0);
    step();

    // Reset in WAIT with rvalid in the same cycle.
    req_q.push_back('{we: 1'b0, be: 4'b1111, addr: 32'h6000, wdata: 32'd0, chk_wdata: 1'b0});
    issue(1'b1, 1'b0, OP_LW, 5'd14, 32'h6000, 32'd0);
    dmem_gnt = 1'b1;
    step();
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata = 32'h1111_1111;
    rstn = 1'b0;
    step();
    dmem_rvalid = 1'b0;
    dmem_rdata = 32'd0;
    rstn = 1'b1;
    @(negedge clk);
    check("rstw_regwr", 32'(o_RegWrEn), 32'd0);
    check("rstw_stall", 32'(o_StallEn), 32'd0);
    check("rstw_req", 32'(o_DMem_req), 32'd0);
    check("rstw_be", 32'(o_DMem_be), 32'd0);
    check("rstw_addr", o_DMem_addr, 32'd0);
    check("rstw_event", 32'(o_Event), 32'd0);
    repeat (4) step();

    // Every queued expectation must have been consumed.
    check("wb_q_empty", 32'(wb_q.size()), 32'd0);
    check("req_q_empty", 32'(req_q.size()), 32'd0);
    check("ev_q_empty", 32'(ev_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
